sine_freq_meter: RTL and testbench
==================================

# sine_freq_meter

Receive-side companion to the quarter-wave sine DDS: consumes a stream of signed 16-bit sine samples and recovers the DDS tuning word that produced them. It detects rising zero crossings with hysteresis, accumulates the sample count over 2^LOG2_AVG periods, and runs an iterative divider to produce `o_phase_step = 2^32 / period`. It sits after the generator, or after an ADC path, in loopback and self-test benches, and in frequency-lock monitoring.

## Interface
- `HYST`, default 256: hysteresis threshold; arming requires a sample below -HYST.
- `CNT_W`, default 24: width of the per-period sample counter; max measurable period 2^CNT_W-1 samples.
- `LOG2_AVG`, default 2: averaging window of 2^LOG2_AVG periods.
- `i_clk`  input  1  single clock.
- `i_rst_n`  input  1  reset, asynchronous, active-low.
- `i_sample`  input  16  signed sine sample.
- `i_sample_valid`  input  1  qualifies `i_sample`; only valid cycles count.
- `o_phase_step`  output  32  recovered tuning word, held between updates.
- `o_phase_step_valid`  output  1  one-cycle pulse when `o_phase_step` updates.
- `o_locked`  output  1  high after the first complete measurement and until timeout or reset.
- `o_timeout`  output  1  one-cycle pulse when a period exceeds the counter range.

## Operation
- Crossing detector, evaluated on valid samples only:
  - `arm` sets when `i_sample < -HYST`.
  - Rising crossing = `arm` set and `i_sample >= 0`; `arm` clears on the crossing.
  - Minimum detectable period is 2 samples.
- Period counter `cnt` (CNT_W bits):
  - Increments on every valid sample.
  - On a crossing, the period equals `cnt+1` (the crossing sample is included), and `cnt` reloads to 0.
- Measurement FSM states: SEEK, FIRST, ACCUM.
  - SEEK (reset state): waits for a first crossing, which goes to FIRST with `cnt=0` and `sum=0`. The partial period before it is discarded.
  - FIRST/ACCUM: each crossing adds its period to `sum` (CNT_W+LOG2_AVG bits) and increments the period index.
  - When 2^LOG2_AVG periods are summed: hand `sum` to the divider if it is idle, clear `sum`, and stay in ACCUM. Consecutive windows are back-to-back and share boundary crossings.
  - If the divider is busy, the window is discarded; `sum` still clears.
- Timeout: if `cnt` reaches 2^CNT_W-1 without a crossing:
  - pulse `o_timeout` and clear `o_locked`;
  - return to SEEK with `arm`=0;
  - leave `o_phase_step` holding its last value.
- Divider: restoring, one quotient bit per cycle, MSB first, 32 iterations.
  - Computes floor(2^(32+LOG2_AVG) / sum).
  - The result always fits in 32 bits because sum >= 2^(LOG2_AVG+1).
  - On completion: `o_phase_step` loads the result, `o_phase_step_valid` pulses, and `o_locked` sets.
- A timeout during a divide does not abort the divide. Its result is still published, but `o_locked` stays low until the next result that is not preceded by a timeout.

## Timing
- Reset values: `o_phase_step`=0, `o_phase_step_valid`=0, `o_locked`=0, `o_timeout`=0, FSM=SEEK, `arm`=0, `cnt`=0, `sum`=0, divider idle.
- Reset asserted mid-divide aborts the divide immediately. No valid pulse follows deassertion.
- Latency: the window-closing crossing sample is registered at edge T, and `o_phase_step_valid` is high in the cycle after edge T+33. That is 1 cycle to latch, 32 iterations, and 1 cycle to register the output.
- Divider busy for 33 cycles. Windows shorter than 34 valid samples are discarded while it is busy.
- `i_sample_valid` low freezes the detector, counter and sum. The divider keeps running.
- `o_timeout` fires on the valid sample that brings `cnt` to its maximum value.

## Test plan
- DDS loopback with phase_step = 2^24 (period 256): first valid pulse after 1+4 crossings; `o_phase_step` = 16777216 ±1; `o_locked`=1.
- Step phase_step from 2^24 to 2^26 (period 64): next result after reacquisition = 67108864 ±1. No timeout. `o_locked` stays high.
- Sine with noise of ±(HYST-1) around zero: exactly one crossing per period; result matches the clean case.
- Drive `i_sample`=0 constantly after lock: after 2^24-1 valid samples, `o_timeout` pulses once; `o_locked`=0; `o_phase_step` holds.
- Deassert `i_sample_valid` on alternate cycles with phase_step 2^24: result unchanged (16777216 ±1), since rate is per valid sample.
- Assert `i_rst_n`=0 during a divide (cycle 10 of 32): all outputs go to 0 at once, and no stray `o_phase_step_valid` pulse appears after release.

Source files
------------

// File: rtl/sine_freq_meter.sv
// Sine frequency meter: finds rising zero crossings with hysteresis, sums the
// sample count over 2^LOG2_AVG periods, and divides 2^(32+LOG2_AVG) by that sum
// to recover the DDS phase step.
module sine_freq_meter #(
    parameter int HYST     = 256,
    parameter int CNT_W    = 24,
    parameter int LOG2_AVG = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [15:0] i_sample,
    input  logic        i_sample_valid,
    output logic [31:0] o_phase_step,
    output logic        o_phase_step_valid,
    output logic        o_locked,
    output logic        o_timeout
);

    localparam int SUM_W = CNT_W + LOG2_AVG;
    localparam int IDX_W = (LOG2_AVG > 0) ? LOG2_AVG : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'((1 << LOG2_AVG) - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_MAX - CNT_W'(1);
    localparam logic signed [16:0] NEG_HYST = 17'(-HYST);

    localparam logic [1:0] ST_SEEK  = 2'd0;
    localparam logic [1:0] ST_FIRST = 2'd1;
    localparam logic [1:0] ST_ACCUM = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             arm_q, arm_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic             busy_q, busy_d;
    logic [5:0]       iter_q, iter_d;
    logic [SUM_W-1:0] rem_q, rem_d;
    logic [31:0]      quot_q, quot_d;
    logic [SUM_W-1:0] div_q, div_d;
    logic             tmoSeen_q, tmoSeen_d;

    logic [31:0]      step_q, step_d;
    logic             stepValid_q, stepValid_d;
    logic             locked_q, locked_d;
    logic             timeout_q, timeout_d;

    logic signed [16:0] sampleExt;
    logic               belowArm;
    logic               crossing;
    logic               timeoutHit;
    logic               windowDone;
    logic               startDiv;
    logic [CNT_W-1:0]   period;
    logic [SUM_W-1:0]   windowSum;
    logic [SUM_W:0]     trial;
    logic [SUM_W:0]     trialDiff;
    logic               trialGe;

    assign sampleExt  = {i_sample[15], i_sample};
    assign belowArm   = sampleExt < NEG_HYST;
    assign crossing   = i_sample_valid && arm_q && !i_sample[15];
    // Timeout only matters once a measurement is in progress; while seeking the
    // counter just saturates so a dead input does not keep re-firing it.
    assign timeoutHit = i_sample_valid && !crossing && (state_q != ST_SEEK) && (cnt_q == CNT_LAST);
    assign period     = cnt_q + CNT_W'(1);
    assign windowSum  = sum_q + SUM_W'(period);
    assign windowDone = crossing && (state_q != ST_SEEK) && (idx_q == IDX_LAST);
    assign startDiv   = windowDone && !busy_q;
    assign trial      = {rem_q, 1'b0};
    assign trialGe    = trial >= {1'b0, div_q};
    assign trialDiff  = trial - {1'b0, div_q};

    // Crossing detector and per-period sample counter, frozen on invalid samples
    always_comb begin
        arm_d = arm_q;
        cnt_d = cnt_q;
        if (i_sample_valid) begin
            if (crossing || timeoutHit) begin
                arm_d = 1'b0;
                cnt_d = '0;
            end else begin
                if (belowArm) arm_d = 1'b1;
                if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Measurement FSM: sums 2^LOG2_AVG periods, windows share boundary crossings
    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        if (timeoutHit) begin
            state_d = ST_SEEK;
            sum_d   = '0;
            idx_d   = '0;
        end else if (crossing) begin
            if (state_q == ST_SEEK) begin
                state_d = ST_FIRST;
                sum_d   = '0;
                idx_d   = '0;
            end else if (idx_q == IDX_LAST) begin
                state_d = ST_ACCUM;
                sum_d   = '0;
                idx_d   = '0;
            end else begin
                sum_d = windowSum;
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    // Restoring divider (one quotient bit per cycle) and output registers
    always_comb begin
        busy_d      = busy_q;
        iter_d      = iter_q;
        rem_d       = rem_q;
        quot_d      = quot_q;
        div_d       = div_q;
        tmoSeen_d   = tmoSeen_q;
        step_d      = step_q;
        stepValid_d = 1'b0;
        locked_d    = locked_q;
        timeout_d   = timeoutHit;
        if (timeoutHit) begin
            locked_d  = 1'b0;
            tmoSeen_d = 1'b1;
        end
        if (busy_q) begin
            if (iter_q == 6'd32) begin
                busy_d      = 1'b0;
                step_d      = quot_q;
                stepValid_d = 1'b1;
                locked_d    = !(tmoSeen_q || timeoutHit);
            end else begin
                rem_d  = trialGe ? SUM_W'(trialDiff) : SUM_W'(trial);
                quot_d = {quot_q[30:0], trialGe};
                iter_d = iter_q + 6'd1;
            end
        end else if (startDiv) begin
            // The dividend's bits above the 32 quotient positions are just
            // 2^LOG2_AVG, always below the divisor, so they seed the remainder.
            busy_d    = 1'b1;
            iter_d    = '0;
            rem_d     = SUM_W'(1) << LOG2_AVG;
            quot_d    = '0;
            div_d     = windowSum;
            tmoSeen_d = 1'b0;
        end
    end

    // State registers; reset aborts any divide in flight
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_SEEK;
            arm_q       <= 1'b0;
            cnt_q       <= '0;
            sum_q       <= '0;
            idx_q       <= '0;
            busy_q      <= 1'b0;
            iter_q      <= '0;
            rem_q       <= '0;
            quot_q      <= '0;
            div_q       <= '0;
            tmoSeen_q   <= 1'b0;
            step_q      <= '0;
            stepValid_q <= 1'b0;
            locked_q    <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            arm_q       <= arm_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            idx_q       <= idx_d;
            busy_q      <= busy_d;
            iter_q      <= iter_d;
            rem_q       <= rem_d;
            quot_q      <= quot_d;
            div_q       <= div_d;
            tmoSeen_q   <= tmoSeen_d;
            step_q      <= step_d;
            stepValid_q <= stepValid_d;
            locked_q    <= locked_d;
            timeout_q   <= timeout_d;
        end
    end

    assign o_phase_step       = step_q;
    assign o_phase_step_valid = stepValid_q;
    assign o_locked           = locked_q;
    assign o_timeout          = timeout_q;

endmodule

// File: tb/tb_sine_freq_meter.sv
// Bench for sine_freq_meter: drives DDS-style sines, square patterns and zeros,
// and compares every cycle against a crossing/window/division model.
module tb_sine_freq_meter;

    localparam int HYST     = 256;
    localparam int CNT_W    = 12;
    localparam int LOG2_AVG = 2;
    localparam int AVG      = 1 << LOG2_AVG;
    localparam int MAXP     = (1 << CNT_W) - 1;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic signed [15:0] sample = '0;
    logic               sampleValid = 1'b0;
    logic [31:0]        phaseStep;
    logic               phaseStepValid;
    logic               locked;
    logic               timeoutPulse;

    sine_freq_meter #(
        .HYST(HYST),
        .CNT_W(CNT_W),
        .LOG2_AVG(LOG2_AVG)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_sample(sample),
        .i_sample_valid(sampleValid),
        .o_phase_step(phaseStep),
        .o_phase_step_valid(phaseStepValid),
        .o_locked(locked),
        .o_timeout(timeoutPulse)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Model state: crossings are tracked by valid-sample index, periods are index
    // differences, and the divider is just an integer division due 33 edges later.
    bit          mArm = 1'b0;
    bit          mSeek = 1'b1;
    bit          mTmo = 1'b0;
    int          vIdx = 0;
    int          lastCross = 0;
    int          winN = 0;
    longint      winSum = 0;
    bit          pending = 1'b0;
    bit          pendTmo = 1'b0;
    longint      pubEdge = 0;
    longint      pubVal = 0;
    longint      edgeNum = 0;
    int          modelTmoCount = 0;
    logic [31:0] expStep = '0;
    logic        expValid = 1'b0;
    logic        expLocked = 1'b0;
    logic        expTimeout = 1'b0;

    // Bench bookkeeping from observed outputs
    bit          checking = 1'b0;
    bit          trackLock = 1'b0;
    int          lockDrops = 0;
    int          validCount = 0;
    int          tmoCount = 0;
    int          firstPulseDrive = -1;
    logic [31:0] lastResult = '0;
    int unsigned phaseAcc = 0;
    int          driveCount = 0;

    task automatic checkOutput(input string name, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edgeNum);
        end
    endtask

    task automatic checkRange(input string name, input longint act, input longint lo, input longint hi);
        vectors++;
        if (act < lo || act > hi) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d..%0d (edge %0d)", name, act, lo, hi, edgeNum);
        end
    endtask

    function automatic int sineAt(input int unsigned ph);
        real r;
        r = 20000.0 * $sin(6.283185307179586 * real'(ph) / 4294967296.0);
        return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
    endfunction

    // Reference model, evaluated on each active edge with the inputs the DUT sees
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mArm = 1'b0; mSeek = 1'b1; winN = 0; winSum = 0;
            pending = 1'b0; pendTmo = 1'b0;
            expStep = '0; expValid = 1'b0; expLocked = 1'b0; expTimeout = 1'b0;
        end else begin
            edgeNum++;
            expValid = 1'b0;
            expTimeout = 1'b0;
            mTmo = 1'b0;
            if (sampleValid) begin
                vIdx++;
                if (mArm && sample >= 0) begin
                    mArm = 1'b0;
                    if (mSeek) begin
                        mSeek = 1'b0; winN = 0; winSum = 0;
                    end else begin
                        winSum += longint'(vIdx - lastCross);
                        winN++;
                        if (winN == AVG) begin
                            if (!pending) begin
                                pending = 1'b1;
                                pendTmo = 1'b0;
                                pubEdge = edgeNum + 33;
                                pubVal  = (longint'(1) << (32 + LOG2_AVG)) / winSum;
                            end
                            winN = 0; winSum = 0;
                        end
                    end
                    lastCross = vIdx;
                end else begin
                    if (sample < -HYST) mArm = 1'b1;
                    if (!mSeek && (vIdx - lastCross) == MAXP) begin
                        mTmo = 1'b1; mSeek = 1'b1; mArm = 1'b0; winN = 0; winSum = 0;
                    end
                end
            end
            if (mTmo) begin
                expTimeout = 1'b1;
                expLocked = 1'b0;
                modelTmoCount++;
                if (pending) pendTmo = 1'b1;
            end
            if (pending && edgeNum == pubEdge) begin
                pending = 1'b0;
                expStep = 32'(pubVal);
                expValid = 1'b1;
                expLocked = !pendTmo;
            end
        end
    end

    // Per-cycle compare, sampled just after the inactive edge
    initial forever begin
        @(negedge clk);
        #1;
        if (checking) begin
            checkOutput("o_phase_step", phaseStep, expStep);
            checkOutput("o_phase_step_valid", phaseStepValid, expValid);
            checkOutput("o_locked", locked, expLocked);
            checkOutput("o_timeout", timeoutPulse, expTimeout);
            if (phaseStepValid) begin
                if (validCount == 0) firstPulseDrive = driveCount;
                validCount++;
                lastResult = phaseStep;
            end
            if (timeoutPulse) tmoCount++;
            if (trackLock && !locked) lockDrops++;
        end
    end

    // Phase-accumulator sine; validMode 0 = every cycle, 1 = alternate, 2 = random 75%
    task automatic applyStimulus(input int nCycles, input int unsigned step, input int noiseAmp, input int validMode);
        for (int i = 0; i < nCycles; i++) begin
            bit v;
            int nz;
            @(negedge clk);
            driveCount++;
            case (validMode)
                0:       v = 1'b1;
                1:       v = (driveCount % 2) == 1;
                default: v = ($urandom_range(99) < 75);
            endcase
            if (v) begin
                nz = (noiseAmp > 0) ? int'($urandom_range(2 * noiseAmp)) - noiseAmp : 0;
                sample = 16'(sineAt(phaseAcc) + nz);
                phaseAcc += step;
            end else begin
                sample = 16'($urandom);
            end
            sampleValid = v;
        end
    endtask

    // One arming sample then zeros: gives a crossing exactly every 'period' samples
    task automatic applySquare(input int period, input int nPeriods);
        for (int p = 0; p < nPeriods; p++) begin
            for (int k = 0; k < period; k++) begin
                @(negedge clk);
                driveCount++;
                sampleValid = 1'b1;
                sample = (k == 0) ? -16'sd300 : 16'sd0;
            end
        end
    endtask

    task automatic applyZeros(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            driveCount++;
            sampleValid = 1'b1;
            sample = '0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: time limit reached, vectors=%0d miscompares=%0d", vectors, miscompares);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int baseTmo;
        int baseValid;
        int baseModelTmo;
        logic [31:0] held;
        bit found;

        @(negedge clk);
        checking = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        checkOutput("reset_step", phaseStep, 0);
        checkOutput("reset_valid", phaseStepValid, 0);
        checkOutput("reset_locked", locked, 0);
        checkOutput("reset_timeout", timeoutPulse, 0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] loopback, period 256");
        applyStimulus(2600, 32'h0100_0000, 0, 0);
        checkOutput("first_pulse_drive", firstPulseDrive, 1315);
        checkRange("loop_256", lastResult, 16777215, 16777217);
        checkOutput("loop_locked", locked, 1);
        checkOutput("model_loop_256", expStep, 16777216);

        $display("[TB] step to period 64");
        baseTmo = tmoCount;
        lockDrops = 0;
        trackLock = 1'b1;
        applyStimulus(1600, 32'h0400_0000, 0, 0);
        trackLock = 1'b0;
        checkRange("loop_64", lastResult, 67108863, 67108865);
        checkOutput("step_no_timeout", tmoCount - baseTmo, 0);
        checkOutput("step_lock_held", lockDrops, 0);
        checkOutput("model_loop_64", expStep, 67108864);

        $display("[TB] noisy sine, period 256");
        applyStimulus(3000, 32'h0100_0000, HYST - 1, 0);
        checkRange("noise_256", lastResult, 16609444, 16944988);

        $display("[TB] alternate valid, period 256");
        baseValid = validCount;
        applyStimulus(5200, 32'h0100_0000, 0, 1);
        checkRange("alt_pulses", validCount - baseValid, 1, 1000);
        checkRange("alt_256", lastResult, 16777215, 16777217);
        checkOutput("pre_zero_locked", locked, 1);

        $display("[TB] constant zero until timeout");
        held = lastResult;
        baseTmo = tmoCount;
        baseModelTmo = modelTmoCount;
        applyZeros(4300);
        checkOutput("zero_timeouts", tmoCount - baseTmo, 1);
        checkOutput("model_zero_timeouts", modelTmoCount - baseModelTmo, 1);
        checkOutput("zero_unlocked", locked, 0);
        checkOutput("zero_step_held", phaseStep, held);

        $display("[TB] maximum period 4095");
        baseTmo = tmoCount;
        applySquare(MAXP, 6);
        checkOutput("max_period", lastResult, 1048832);
        checkOutput("model_max_period", expStep, 1048832);
        checkOutput("max_no_timeout", tmoCount - baseTmo, 0);
        checkOutput("max_relocked", locked, 1);

        $display("[TB] minimum period 2");
        applySquare(2, 200);
        checkOutput("min_period", lastResult, 64'd2147483648);
        checkOutput("model_min_period", expStep, 64'd2147483648);

        $display("[TB] reset during divide");
        found = 1'b0;
        for (int i = 0; i < 4000 && !found; i++) begin
            applyStimulus(1, 32'h0100_0000, 0, 2);
            if (pending && (pubEdge - edgeNum) == 23) found = 1'b1;
        end
        checkOutput("divide_reached", found, 1);
        rst_n = 1'b0;
        #2;
        checkOutput("rst_step", phaseStep, 0);
        checkOutput("rst_valid", phaseStepValid, 0);
        checkOutput("rst_locked", locked, 0);
        checkOutput("rst_timeout", timeoutPulse, 0);
        baseValid = validCount;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(300, 32'h0100_0000, 0, 0);
        checkOutput("no_stray_valid", validCount - baseValid, 0);
        checkOutput("post_rst_step", phaseStep, 0);

        @(negedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
